// File: rtl/debug_pkg.sv
// rtl/debug_pkg.sv - shared FSM encoding, header byte and snapshot field widths
package debug_pkg;

    typedef enum logic [1:0] {
        SER_IDLE,
        SER_ISSUE,
        SER_WAIT,
        SER_FINISH
    } ser_state_t;

    localparam logic [7:0] HEADER_DEFAULT = 8'hA5;

    localparam int INSTR_W = 32;
    localparam int PC_W    = 7;
    localparam int IF_ID_W = 39;
    localparam int ID_EX_W = 127;
    localparam int EX_M_W  = 72;
    localparam int M_WB_W  = 71;
    localparam int REGS_W  = 1024;
    localparam int DMEM_W  = 32;

    localparam int SNAP_STATE_W = INSTR_W + PC_W + IF_ID_W + ID_EX_W
                                + EX_M_W + M_WB_W + REGS_W + DMEM_W;
    // The debug unit zero-pads the state up to a whole number of bytes.
    localparam int SNAP_W = ((SNAP_STATE_W + 7) / 8) * 8;

    function automatic int frame_idx_w(input int data_w);
        return $clog2(data_w / 8 + 2);
    endfunction

endpackage

// File: rtl/snapshot_serializer_if.sv
// rtl/snapshot_serializer_if.sv - byte handshake between the serializer and uart_tx
interface snapshot_serializer_if;

    logic       tx_start;
    logic [7:0] tx_bus;
    logic       tx_done_tick;

    modport master (
        output tx_start,
        output tx_bus,
        input  tx_done_tick
    );

    modport slave (
        input  tx_start,
        input  tx_bus,
        output tx_done_tick
    );

endinterface

// File: rtl/byte_mux_shadow.sv
// rtl/byte_mux_shadow.sv - shadow copy of the snapshot and data-byte selector
module byte_mux_shadow #(
    parameter int DATA_W = 32,
    parameter int IDX_W  = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic [DATA_W-1:0] snap_data,
    input  logic [IDX_W-1:0]  data_idx,
    output logic [7:0]        data_byte
);

    logic [DATA_W-1:0] shadow_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shadow_q <= '0;
        end else if (load) begin
            shadow_q <= snap_data;
        end
    end

    // Byte k lives at bits [8k+7:8k]; indices past the end read as zero.
    assign data_byte = 8'(shadow_q >> {data_idx, 3'b000});

endmodule

// File: rtl/snapshot_serializer.sv
// rtl/snapshot_serializer.sv - frames a captured snapshot into header, data bytes and XOR checksum
module snapshot_serializer
    import debug_pkg::*;
#(
    parameter int         DATA_W  = SNAP_W,
    parameter logic [7:0] HEADER  = HEADER_DEFAULT,
    parameter int         TIMEOUT = 65535
) (
    input  logic                  top_clk,
    input  logic                  top_rst,
    input  logic                  start,
    input  logic [DATA_W-1:0]     snap_data,
    snapshot_serializer_if.master uart,
    output logic                  busy,
    output logic                  frame_done,
    output logic                  timeout_err
);

    localparam int N     = DATA_W / 8;
    localparam int IDX_W = frame_idx_w(DATA_W);
    localparam int WD_W  = $clog2(TIMEOUT + 1);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N + 1);
    localparam logic [WD_W-1:0]  WD_LIMIT = WD_W'(TIMEOUT - 1);

    ser_state_t       state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [7:0]       csum_q, csum_d;
    logic [WD_W-1:0]  wdog_q, wdog_d;

    logic             load;
    logic             is_data;
    logic [IDX_W-1:0] data_idx;
    logic [7:0]       data_byte;
    logic [7:0]       cur_byte;
    logic             tx_start_c;
    logic [7:0]       tx_bus_c;

    byte_mux_shadow #(
        .DATA_W (DATA_W),
        .IDX_W  (IDX_W)
    ) u_byte_mux_shadow (
        .clk       (top_clk),
        .rst_n     (top_rst),
        .load      (load),
        .snap_data (snap_data),
        .data_idx  (data_idx),
        .data_byte (data_byte)
    );

    assign data_idx = idx_q - 1'b1;
    assign is_data  = (idx_q != '0) && (idx_q != LAST_IDX);
    assign cur_byte = (idx_q == '0)      ? HEADER :
                      (idx_q == LAST_IDX) ? csum_q : data_byte;

    always_ff @(posedge top_clk or negedge top_rst) begin
        if (!top_rst) begin
            state_q <= SER_IDLE;
            idx_q   <= '0;
            csum_q  <= '0;
            wdog_q  <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            csum_q  <= csum_d;
            wdog_q  <= wdog_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        csum_d      = csum_q;
        wdog_d      = wdog_q;
        load        = 1'b0;
        tx_start_c  = 1'b0;
        tx_bus_c    = 8'h00;
        frame_done  = 1'b0;
        timeout_err = 1'b0;

        case (state_q)
            SER_IDLE: begin
                if (start) begin
                    load    = 1'b1;
                    idx_d   = '0;
                    csum_d  = '0;
                    state_d = SER_ISSUE;
                end
            end
            SER_ISSUE: begin
                tx_start_c = 1'b1;
                tx_bus_c   = cur_byte;
                wdog_d     = '0;
                if (is_data) begin
                    csum_d = csum_q ^ data_byte;
                end
                state_d = SER_WAIT;
            end
            SER_WAIT: begin
                tx_bus_c = cur_byte;
                // An acknowledge in the last watchdog cycle still wins over the abort.
                if (uart.tx_done_tick) begin
                    if (idx_q == LAST_IDX) begin
                        state_d = SER_FINISH;
                    end else begin
                        idx_d   = idx_q + 1'b1;
                        state_d = SER_ISSUE;
                    end
                end else if (wdog_q == WD_LIMIT) begin
                    timeout_err = 1'b1;
                    state_d     = SER_IDLE;
                end else begin
                    wdog_d = wdog_q + 1'b1;
                end
            end
            SER_FINISH: begin
                frame_done = 1'b1;
                state_d    = SER_IDLE;
            end
            default: begin
                state_d = SER_IDLE;
            end
        endcase
    end

    assign busy          = (state_q != SER_IDLE);
    assign uart.tx_start = tx_start_c;
    assign uart.tx_bus   = tx_bus_c;

endmodule

// File: tb/tb_snapshot_serializer.sv
// tb/tb_snapshot_serializer.sv - scoreboard bench for the snapshot serializer
module tb_snapshot_serializer;
    import debug_pkg::*;

    localparam int SW   = 32;
    localparam int S_TO = 20;
    localparam int BW   = SNAP_W;

    logic top_clk = 1'b0;
    logic rst_n   = 1'b0;

    logic          start_s = 1'b0;
    logic [SW-1:0] snap_s  = '0;
    logic          busy_s, fd_s, te_s;
    logic          start_b = 1'b0;
    logic [BW-1:0] snap_b  = '0;
    logic          busy_b, fd_b, te_b;

    snapshot_serializer_if if_s();
    snapshot_serializer_if if_b();

    snapshot_serializer #(.DATA_W(SW), .TIMEOUT(S_TO)) u_small (
        .top_clk     (top_clk),
        .top_rst     (rst_n),
        .start       (start_s),
        .snap_data   (snap_s),
        .uart        (if_s),
        .busy        (busy_s),
        .frame_done  (fd_s),
        .timeout_err (te_s)
    );

    snapshot_serializer u_big (
        .top_clk     (top_clk),
        .top_rst     (rst_n),
        .start       (start_b),
        .snap_data   (snap_b),
        .uart        (if_b),
        .busy        (busy_b),
        .frame_done  (fd_b),
        .timeout_err (te_b)
    );

    always #5 top_clk = ~top_clk;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    logic [7:0] exp_s[$];
    logic [7:0] exp_b[$];

    int starts_s = 0, frames_s = 0, timeouts_s = 0;
    int starts_b = 0, frames_b = 0;
    int ack_seen_s = 0, ack_cyc_s = 0, last_start_cyc_s = 0;
    logic [7:0] last_byte_s = 8'h00;

    int delay_s = 10, drop_s = -1, model_cnt_s = 0;

    always @(posedge top_clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference framing: header, data bytes LSB-first, XOR of data bytes only.
    task automatic push_frame(input logic [BW-1:0] snap, input int nbytes, input int keep, input bit big);
        logic [7:0] frame[$];
        logic [7:0] x;
        x = 8'h00;
        frame.push_back(8'hA5);
        for (int k = 0; k < nbytes; k++) begin
            frame.push_back(snap[8*k +: 8]);
            x = x ^ snap[8*k +: 8];
        end
        frame.push_back(x);
        for (int i = 0; i < keep; i++) begin
            if (big) exp_b.push_back(frame[i]);
            else     exp_s.push_back(frame[i]);
        end
    endtask

    // UART model for the small instance: acks delay_s cycles after tx_start, or never for drop_s.
    always begin
        @(negedge top_clk);
        if (rst_n && if_s.tx_start) begin
            model_cnt_s++;
            if (model_cnt_s != drop_s) begin
                repeat (delay_s) @(posedge top_clk);
                #1 if_s.tx_done_tick = 1'b1;
                @(posedge top_clk);
                #1 if_s.tx_done_tick = 1'b0;
            end
        end
    end

    always begin
        @(negedge top_clk);
        if (rst_n && if_b.tx_start) begin
            repeat (2) @(posedge top_clk);
            #1 if_b.tx_done_tick = 1'b1;
            @(posedge top_clk);
            #1 if_b.tx_done_tick = 1'b0;
        end
    end

    // Monitors: pop the scoreboard on every tx_start and check handshake timing.
    always @(negedge top_clk) begin
        if (!rst_n) begin
            ack_seen_s = 0;
        end else begin
            if (if_s.tx_start) begin
                if (exp_s.size() == 0) check("unexpected_tx_start_s", 1, 0);
                else check("tx_byte_s", int'(if_s.tx_bus), int'(exp_s.pop_front()));
                if (ack_seen_s != 0) check("issue_after_ack_s", cyc - ack_cyc_s, 1);
                ack_seen_s       = 0;
                last_byte_s      = if_s.tx_bus;
                last_start_cyc_s = cyc;
                starts_s++;
            end
            if (if_s.tx_done_tick && busy_s && !if_s.tx_start) begin
                check("tx_bus_hold_s", int'(if_s.tx_bus), int'(last_byte_s));
                ack_seen_s = 1;
                ack_cyc_s  = cyc;
            end
            if (fd_s) begin
                frames_s++;
                check("done_after_last_ack_s", cyc - ack_cyc_s, 1);
                ack_seen_s = 0;
            end
            if (te_s) begin
                timeouts_s++;
                check("timeout_latency_s", cyc - last_start_cyc_s, S_TO);
            end
        end
    end

    always @(negedge top_clk) begin
        if (rst_n) begin
            if (if_b.tx_start) begin
                starts_b++;
                if (exp_b.size() == 0) check("unexpected_tx_start_b", 1, 0);
                else check("tx_byte_b", int'(if_b.tx_bus), int'(exp_b.pop_front()));
            end
            if (fd_b) frames_b++;
            if (te_b) check("unexpected_timeout_b", 1, 0);
        end
    end

    task automatic send_s(input logic [SW-1:0] snap, input int keep);
        @(negedge top_clk);
        start_s = 1'b1;
        snap_s  = snap;
        push_frame(BW'(snap), SW / 8, keep, 1'b0);
        @(negedge top_clk);
        start_s = 1'b0;
        check("first_tx_start_latency", int'(if_s.tx_start), 1);
        check("busy_rises", int'(busy_s), 1);
    endtask

    // Returns at the negedge of the frame_done / timeout_err cycle.
    task automatic wait_end_s(input bit expect_to, input int budget);
        int busy_low;
        bit got;
        bit was_to;
        busy_low = 0;
        got      = 1'b0;
        was_to   = 1'b0;
        for (int i = 0; i < budget && !got; i++) begin
            @(negedge top_clk);
            if (!busy_s) busy_low++;
            if (fd_s || te_s) begin
                got    = 1'b1;
                was_to = te_s;
            end
        end
        check("frame_end_seen", int'(got), 1);
        check("end_kind_timeout", int'(was_to), int'(expect_to));
        check("busy_through_frame", busy_low, 0);
    endtask

    initial begin
        #1000000;
        $display("FAIL global_time_limit: got no finish, expected finish");
        $fatal(1, "time limit");
    end

    initial begin
        int base, fbase, tbase;
        logic [SW-1:0] r;
        bit got;

        if_s.tx_done_tick = 1'b0;
        if_b.tx_done_tick = 1'b0;
        repeat (3) @(negedge top_clk);
        check("reset_tx_start", int'(if_s.tx_start), 0);
        check("reset_tx_bus", int'(if_s.tx_bus), 0);
        check("reset_busy", int'(busy_s), 0);
        check("reset_frame_done", int'(fd_s), 0);
        check("reset_timeout_err", int'(te_s), 0);
        check("reset_busy_big", int'(busy_b), 0);
        rst_n = 1'b1;
        repeat (2) @(negedge top_clk);

        // Fixed frame with a start mid-frame that must be ignored.
        delay_s = 10;
        base  = starts_s;
        fbase = frames_s;
        send_s(32'h11223344, 6);
        repeat (20) @(negedge top_clk);
        start_s = 1'b1;
        snap_s  = 32'hFFFFFFFF;
        @(negedge top_clk);
        start_s = 1'b0;
        wait_end_s(1'b0, 500);
        @(negedge top_clk);
        check("busy_falls", int'(busy_s), 0);
        check("starts_per_frame", starts_s - base, 6);
        check("frames_count", frames_s - fbase, 1);
        check("queue_drained", exp_s.size(), 0);

        // All-zero frame, then start during FINISH (ignored) and in the first IDLE cycle (accepted).
        delay_s = 3;
        fbase = frames_s;
        send_s(32'h00000000, 6);
        wait_end_s(1'b0, 500);
        start_s = 1'b1;
        snap_s  = 32'hDEADBEEF;
        @(negedge top_clk);
        check("idle_after_finish", int'(busy_s), 0);
        r = $urandom;
        snap_s = r;
        push_frame(BW'(r), SW / 8, 6, 1'b0);
        @(negedge top_clk);
        start_s = 1'b0;
        check("back_to_back_issue", int'(if_s.tx_start), 1);
        wait_end_s(1'b0, 500);
        @(negedge top_clk);
        check("back_to_back_frames", frames_s - fbase, 2);

        // Randomized frames with random ack latency; snap_data is scrambled after capture.
        for (int n = 0; n < 5; n++) begin
            delay_s = $urandom_range(1, 8);
            r = $urandom;
            send_s(r, 6);
            snap_s = $urandom;
            wait_end_s(1'b0, 600);
            @(negedge top_clk);
        end
        check("random_queue_drained", exp_s.size(), 0);

        // Watchdog: the third byte of the frame is never acknowledged.
        delay_s = 10;
        fbase = frames_s;
        tbase = timeouts_s;
        drop_s = model_cnt_s + 3;
        send_s($urandom, 3);
        wait_end_s(1'b1, 500);
        @(negedge top_clk);
        check("busy_after_timeout", int'(busy_s), 0);
        repeat (30) @(negedge top_clk);
        check("no_done_on_timeout", frames_s - fbase, 0);
        check("timeout_count", timeouts_s - tbase, 1);
        check("timeout_queue_drained", exp_s.size(), 0);
        drop_s = -1;
        send_s($urandom, 6);
        wait_end_s(1'b0, 500);
        @(negedge top_clk);
        check("frame_after_timeout", frames_s - fbase, 1);

        // Asynchronous reset during the WAIT of the first data byte.
        delay_s = 10;
        base = starts_s;
        send_s($urandom | 32'h1, 2);
        got = 1'b0;
        for (int i = 0; i < 100 && !got; i++) begin
            @(negedge top_clk);
            if (starts_s >= base + 2) got = 1'b1;
        end
        check("reached_data_byte", int'(got), 1);
        repeat (3) @(negedge top_clk);
        rst_n = 1'b0;
        #1;
        check("async_rst_tx_start", int'(if_s.tx_start), 0);
        check("async_rst_busy", int'(busy_s), 0);
        check("async_rst_tx_bus", int'(if_s.tx_bus), 0);
        repeat (3) @(negedge top_clk);
        rst_n = 1'b1;
        repeat (30) @(negedge top_clk);
        check("no_resume_after_reset", starts_s - base, 2);
        check("idle_after_reset", int'(busy_s), 0);
        check("reset_queue_drained", exp_s.size(), 0);

        // Full-width snapshot: incrementing bytes, then a random one.
        for (int f = 0; f < 2; f++) begin
            base = starts_b;
            fbase = frames_b;
            @(negedge top_clk);
            for (int k = 0; k < BW / 8; k++) begin
                if (f == 0) snap_b[8*k +: 8] = 8'(k);
                else        snap_b[8*k +: 8] = 8'($urandom);
            end
            start_b = 1'b1;
            push_frame(snap_b, BW / 8, BW / 8 + 2, 1'b1);
            @(negedge top_clk);
            start_b = 1'b0;
            check("big_first_issue", int'(if_b.tx_start), 1);
            got = 1'b0;
            for (int i = 0; i < 3000 && !got; i++) begin
                @(negedge top_clk);
                if (fd_b) got = 1'b1;
            end
            check("big_frame_done_seen", int'(got), 1);
            @(negedge top_clk);
            check("big_byte_count", starts_b - base, BW / 8 + 2);
            check("big_frame_count", frames_b - fbase, 1);
            check("big_queue_drained", exp_b.size(), 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
